// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants and PC sequencer state encoding
package riscv_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] PCS_BOOT = 2'd0;
  localparam logic [1:0] PCS_RUN  = 2'd1;
  localparam logic [1:0] PCS_HOLD = 2'd2;
  localparam logic [1:0] PCS_HALT = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = PCS_BOOT,
    ST_RUN  = PCS_RUN,
    ST_HOLD = PCS_HOLD,
    ST_HALT = PCS_HALT
  } pcs_state_e;

endpackage

// File: rtl/pc_step_adder.sv
// rtl/pc_step_adder.sv - combinational pc + STEP, wraps modulo 2^XLEN
module pc_step_adder #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] sum_o
);

  assign sum_o = pc_i + XLEN'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with stall, redirect capture and misalign halt
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_step_o,
  output logic            pc_valid_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALIGN_MASK = (ONE << ALIGN_BITS) - ONE;

  pcs_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] pc_plus;
  logic            bad_target;

  pc_step_adder #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .pc_i  (pc_q),
    .sum_o (pc_plus)
  );

  // Only meaningful when redirect_valid_i is high; a zero mask disables the check.
  assign bad_target = |(redirect_target_i & ALIGN_MASK);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    mis_d   = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid_i) begin
          if (bad_target) begin
            mis_d   = 1'b1;
            state_d = ST_HALT;
          end else if (stall_i) begin
            pend_d  = redirect_target_i;
            state_d = ST_HOLD;
          end else begin
            pc_d = redirect_target_i;
          end
        end else if (!stall_i) begin
          pc_d = pc_plus;
        end
      end
      ST_HOLD: begin
        if (redirect_valid_i && bad_target) begin
          mis_d   = 1'b1;
          state_d = ST_HALT;
        end else if (stall_i) begin
          if (redirect_valid_i) pend_d = redirect_target_i;
        end else begin
          // A redirect arriving on the release cycle is newer than the captured one.
          pc_d    = redirect_valid_i ? redirect_target_i : pend_q;
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus_step_o = pc_plus;
  assign pc_valid_o     = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign misalign_o     = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer (STEP=4/ALIGN=2 and STEP=2/ALIGN=1)
module tb_pc_sequencer;

  logic        clk, rst, stall, rv;
  logic [31:0] tgt;
  logic [31:0] pc_a, pps_a, pc_b, pps_b;
  logic        val_a, mis_a, val_b, mis_b;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(.XLEN(32), .STEP(4), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_valid_i(rv), .redirect_target_i(tgt),
    .pc_o(pc_a), .pc_plus_step_o(pps_a), .pc_valid_o(val_a), .misalign_o(mis_a)
  );

  pc_sequencer #(.XLEN(32), .STEP(2), .RESET_VECTOR(32'h0), .ALIGN_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_valid_i(rv), .redirect_target_i(tgt),
    .pc_o(pc_b), .pc_plus_step_o(pps_b), .pc_valid_o(val_b), .misalign_o(mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0=boot, 1=fetching, 2=halted; a pending flag replaces a hold state.
  logic [31:0] m_pc[2];
  logic [31:0] m_pend[2];
  int          m_phase[2];
  bit          m_hp[2];
  bit          m_mis[2];

  function automatic int step_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int align_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_pend[k] = 32'h0; m_phase[k] = 0; m_hp[k] = 0; m_mis[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic s, input logic r, input logic [31:0] t);
    bit bad;
    bad = (t % (32'd1 << align_of(k))) != 0;
    m_mis[k] = 0;
    if (m_phase[k] == 0) begin
      m_phase[k] = 1;
    end else if (m_phase[k] == 1) begin
      if (r && bad) begin
        m_phase[k] = 2;
        m_mis[k] = 1;
      end else if (s) begin
        if (r) begin m_pend[k] = t; m_hp[k] = 1; end
      end else begin
        if (r)            m_pc[k] = t;
        else if (m_hp[k]) m_pc[k] = m_pend[k];
        else              m_pc[k] = m_pc[k] + 32'(step_of(k));
        m_hp[k] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int k, input string tag);
    logic [31:0] pc, pps;
    logic        v, m;
    pc  = (k == 0) ? pc_a  : pc_b;
    pps = (k == 0) ? pps_a : pps_b;
    v   = (k == 0) ? val_a : val_b;
    m   = (k == 0) ? mis_a : mis_b;
    chk($sformatf("%s[%0d].pc", tag, k), pc, m_pc[k]);
    chk($sformatf("%s[%0d].pc_plus", tag, k), pps, m_pc[k] + 32'(step_of(k)));
    chk($sformatf("%s[%0d].valid", tag, k), {31'b0, v}, {31'b0, m_phase[k] == 1});
    chk($sformatf("%s[%0d].misalign", tag, k), {31'b0, m}, {31'b0, m_mis[k]});
  endtask

  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    stall = s; rv = r; tgt = t;
    model_step(0, s, r, t);
    model_step(1, s, r, t);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, then releases just after an edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_model(0, {tag, "_async"});
    check_model(1, {tag, "_async"});
    @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b0; rv = 1'b0; tgt = 32'h0;
    check_model(0, {tag, "_boot"});
    check_model(1, {tag, "_boot"});
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] pc, input logic v, input logic m);
    vec_t x;
    x.stall = s; x.rv = r; x.tgt = t; x.pc = pc; x.valid = v; x.mis = m;
    return x;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = 32'h0;
    model_reset();

    // Expected values for the STEP=4 / word-aligned instance; row = inputs, then state after the edge.
    vq.push_back(mk(0, 0, 32'h0,        32'h0,        1, 0)); // boot -> run
    vq.push_back(mk(0, 0, 32'h0,        32'h4,        1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'h8,        1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'hC,        1, 0));
    vq.push_back(mk(0, 1, 32'h40,       32'h40,       1, 0));
    vq.push_back(mk(0, 1, 32'h100,      32'h100,      1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'h104,      1, 0));
    vq.push_back(mk(0, 1, 32'h20,       32'h20,       1, 0));
    vq.push_back(mk(1, 1, 32'h200,      32'h20,       1, 0)); // captured while stalled
    vq.push_back(mk(1, 1, 32'h300,      32'h20,       1, 0)); // latest wins
    vq.push_back(mk(1, 0, 32'h0,        32'h20,       1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'h300,      1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'h304,      1, 0));
    vq.push_back(mk(1, 1, 32'h400,      32'h304,      1, 0));
    vq.push_back(mk(0, 1, 32'h500,      32'h500,      1, 0)); // release-cycle redirect beats pending
    vq.push_back(mk(1, 0, 32'h0,        32'h500,      1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'h504,      1, 0));
    vq.push_back(mk(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0));
    vq.push_back(mk(0, 0, 32'h0,        32'h0,        1, 0)); // wrap
    vq.push_back(mk(0, 0, 32'h0,        32'h4,        1, 0));
    vq.push_back(mk(0, 1, 32'h102,      32'h4,        0, 1)); // misaligned -> halt
    vq.push_back(mk(0, 0, 32'h0,        32'h4,        0, 0));
    vq.push_back(mk(0, 1, 32'h200,      32'h4,        0, 0));

    do_reset("reset0");
    foreach (vq[i]) begin
      cycle(vq[i].stall, vq[i].rv, vq[i].tgt);
      chk($sformatf("vec%0d.pc", i), pc_a, vq[i].pc);
      chk($sformatf("vec%0d.pc_plus", i), pps_a, vq[i].pc + 32'd4);
      chk($sformatf("vec%0d.valid", i), {31'b0, val_a}, {31'b0, vq[i].valid});
      chk($sformatf("vec%0d.misalign", i), {31'b0, mis_a}, {31'b0, vq[i].mis});
      check_model(1, $sformatf("vec%0d", i));
    end

    // Reset taken while holding a captured redirect must drop it.
    do_reset("reset1");
    cycle(0, 0, 32'h0);
    cycle(1, 1, 32'h80);
    chk("s6_hold_pc", pc_a, 32'h0);
    do_reset("reset_hold");
    cycle(0, 0, 32'h0);
    chk("s6_boot_pc", pc_a, 32'h0);
    cycle(0, 0, 32'h0);
    chk("s6_no_pending", pc_a, 32'h4);
    check_model(0, "s6");
    check_model(1, "s6");

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      if ($urandom_range(0, 15) == 0) t = t | 32'h2;
      if ($urandom_range(0, 31) == 0) t = t | 32'h1;
      if ((m_phase[0] == 2 && m_phase[1] == 2) || $urandom_range(0, 299) == 0) begin
        do_reset("rand_rst");
      end else begin
        cycle($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, t);
        check_model(0, "rand");
        check_model(1, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
